// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: lsu_mode bit positions, access
// size encodings and the FSM state type.
package lsu_pkg;

    localparam int MODE_MEM   = 4;
    localparam int MODE_STORE = 3;
    localparam int MODE_UNS   = 2;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store data replication and strobes, and
// load lane extraction with sign/zero extension. Size 2'b11 behaves as word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] sd,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wmask,
    output logic [31:0] ldata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rdata[{addr_lo, 3'b000} +: 8];
    assign half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        wdata = sd;
        wmask = 4'b1111;
        ldata = rdata;
        case (size)
            SZ_B: begin
                wdata = {4{sd[7:0]}};
                wmask = 4'b0001 << addr_lo;
                ldata = {{24{~uns & byte_v[7]}}, byte_v};
            end
            SZ_H: begin
                // addr_lo[0] is ignored: halfwords are aligned down
                wdata = {2{sd[15:0]}};
                wmask = 4'b0011 << {addr_lo[1], 1'b0};
                ldata = {{16{~uns & half_v[15]}}, half_v};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one memory transaction per instruction over valid/ready
// buses. Define LSU_MISALIGN_CHECK_EN to trap misaligned half/word accesses.
//
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// sender holds valid and its payload stable until that edge.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] exu_data,
    input  logic [ADDR_W-1:0] store_data,
    input  logic [4:0]        lsu_mode,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [ADDR_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] lsu_data,
    output logic              lsu_err,
    output lsu_state_e        dbg_state
);

    lsu_state_e        state, state_next;
    logic [ADDR_W-1:0] addr_q, sd_q, lsu_data_q;
    logic [4:0]        mode_q;
    logic [31:0]       wdata_al, ldata_al;
    logic [3:0]        wmask_al;
    logic              is_req, is_st, mis;

`ifdef LSU_MISALIGN_CHECK_EN
    logic err_q;
    assign mis = (lsu_mode[1:0] == SZ_H && exu_data[0]) ||
                 (lsu_mode[1] && exu_data[1:0] != 2'b00);
    assign lsu_err = err_q;
`else
    assign mis = 1'b0;
    assign lsu_err = 1'b0;
`endif

    lsu_align u_align (
        .addr_lo (addr_q[1:0]),
        .size    (mode_q[1:0]),
        .uns     (mode_q[MODE_UNS]),
        .sd      (sd_q),
        .rdata   (mem_rdata),
        .wdata   (wdata_al),
        .wmask   (wmask_al),
        .ldata   (ldata_al)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid) state_next = (!lsu_mode[MODE_MEM] || mis) ? ST_DONE : ST_REQ;
            ST_REQ:  if (mem_req_ready) state_next = ST_WAIT;
            ST_WAIT: if (mem_resp_valid) state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Result registers change only on entry into DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '0;
            sd_q       <= '0;
            mode_q     <= '0;
            lsu_data_q <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else if (state == ST_IDLE && in_valid) begin
            addr_q <= exu_data;
            sd_q   <= store_data;
            mode_q <= lsu_mode;
            if (!lsu_mode[MODE_MEM] || mis) lsu_data_q <= exu_data;
`ifdef LSU_MISALIGN_CHECK_EN
            if (!lsu_mode[MODE_MEM] || mis) err_q <= lsu_mode[MODE_MEM] & mis;
`endif
        end else if (state == ST_WAIT && mem_resp_valid) begin
            lsu_data_q <= mode_q[MODE_STORE] ? '0 : ldata_al;
`ifdef LSU_MISALIGN_CHECK_EN
            err_q      <= 1'b0;
`endif
        end
    end

    assign is_req = (state == ST_REQ);
    assign is_st  = is_req & mode_q[MODE_STORE];

    assign in_ready      = (state == ST_IDLE);
    assign mem_req_valid = is_req;
    assign mem_addr      = is_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wen       = is_st;
    assign mem_wdata     = is_st ? wdata_al : '0;
    assign mem_wmask     = is_st ? wmask_al : 4'b0000;
    assign out_valid     = (state == ST_DONE);
    assign lsu_data      = lsu_data_q;
    assign dbg_state     = state;

endmodule
